// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, RX checker states
// and the data-length clamp used by the parity engine.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_EVEN  = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_MARK  = 2'b10,
        PAR_SPACE = 2'b11
    } par_type_e;

    typedef enum logic [1:0] {
        RX_IDLE     = 2'b00,
        RX_ACCUM    = 2'b01,
        RX_WAIT_PAR = 2'b10
    } rx_state_e;

    localparam int MIN_DATA_LEN = 5;

    // Out-of-range lengths fall back to the full word.
    function automatic int clamp_len(input int len, input int max_len);
        return (len < MIN_DATA_LEN || len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/uart_parity_engine_if.sv
// Config, TX word and RX bit-stream bundle between the UART FSMs
// and the parity engine.
interface uart_parity_engine_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
);
    localparam int LEN_WIDTH = $clog2(DATA_WIDTH + 1);

    logic                  par_en;
    logic [1:0]            par_type;
    logic [LEN_WIDTH-1:0]  data_len;
    logic                  data_valid;
    logic [DATA_WIDTH-1:0] parallel_data;
    logic                  par_bit;
    logic                  rx_start;
    logic                  rx_bit_valid;
    logic                  rx_bit;
    logic                  rx_par_valid;
    logic                  rx_par_bit;
    logic                  par_err;
    logic                  rx_busy;
    logic [CNT_WIDTH-1:0]  err_cnt;
    logic                  err_cnt_clr;

    modport master (
        output par_en, par_type, data_len,
        output data_valid, parallel_data,
        output rx_start, rx_bit_valid, rx_bit,
        output rx_par_valid, rx_par_bit,
        output err_cnt_clr,
        input  par_bit, par_err, rx_busy, err_cnt
    );

    modport slave (
        input  par_en, par_type, data_len,
        input  data_valid, parallel_data,
        input  rx_start, rx_bit_valid, rx_bit,
        input  rx_par_valid, rx_par_bit,
        input  err_cnt_clr,
        output par_bit, par_err, rx_busy, err_cnt
    );

endinterface

// File: rtl/parity_rule.sv
// Maps the raw XOR of the data bits to the parity bit
// demanded by the selected parity mode.
module parity_rule
    import uart_pkg::*;
(
    input  logic      raw_xor,
    input  par_type_e par_type,
    output logic      par_out
);

    always_comb begin
        par_out = 1'b0;
        unique case (par_type)
            PAR_EVEN:  par_out = raw_xor;
            PAR_ODD:   par_out = ~raw_xor;
            PAR_MARK:  par_out = 1'b1;
            PAR_SPACE: par_out = 1'b0;
        endcase
    end

endmodule

// File: rtl/uart_parity_engine.sv
// UART parity engine: registered TX parity from a parallel word,
// bit-serial RX parity check with a saturating error counter.
module uart_parity_engine
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input logic               clk,
    input logic               reset_n,
    uart_parity_engine_if.slave bus
);

    localparam int LW = $clog2(DATA_WIDTH + 1);
    typedef logic [LW-1:0] len_t;

    len_t                  eff_len;
    logic [DATA_WIDTH-1:0] tx_mask;
    logic                  tx_xor;
    logic                  tx_par;
    logic                  par_bit_q;

    always_comb begin
        eff_len = len_t'(clamp_len(int'(bus.data_len), DATA_WIDTH));
        tx_mask = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            tx_mask[i] = (i < int'(eff_len));
        end
        tx_xor = ^(bus.parallel_data & tx_mask);
    end

    parity_rule u_tx_rule (
        .raw_xor  (tx_xor),
        .par_type (par_type_e'(bus.par_type)),
        .par_out  (tx_par)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_bit_q <= 1'b0;
        end else if (bus.par_en && bus.data_valid) begin
            par_bit_q <= tx_par;
        end
    end

    assign bus.par_bit = par_bit_q;

    rx_state_e            state_q, state_d;
    logic                 acc_q, acc_d;
    len_t                 cnt_q, cnt_d;
    len_t                 len_q, len_d;
    par_type_e            ptype_q, ptype_d;
    logic                 pen_q, pen_d;
    logic                 err_d, par_err_q;
    logic                 rx_exp;
    logic                 last_bit;
    logic [CNT_WIDTH-1:0] err_cnt_q;

    assign last_bit = (cnt_q == len_q - 1'b1);

    parity_rule u_rx_rule (
        .raw_xor  (acc_q),
        .par_type (ptype_q),
        .par_out  (rx_exp)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RX_IDLE;
            acc_q     <= 1'b0;
            cnt_q     <= '0;
            len_q     <= len_t'(DATA_WIDTH);
            ptype_q   <= PAR_EVEN;
            pen_q     <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            ptype_q   <= ptype_d;
            pen_q     <= pen_d;
            par_err_q <= err_d;
        end
    end

    // A start bit restarts the frame from any state.
    always_comb begin
        state_d = state_q;
        if (bus.rx_start) begin
            state_d = RX_ACCUM;
        end else begin
            case (state_q)
                RX_IDLE: state_d = RX_IDLE;
                RX_ACCUM:
                    if (bus.rx_bit_valid && last_bit)
                        state_d = pen_q ? RX_WAIT_PAR : RX_IDLE;
                RX_WAIT_PAR:
                    if (bus.rx_par_valid)
                        state_d = RX_IDLE;
                default: state_d = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ptype_d = ptype_q;
        pen_d   = pen_q;
        err_d   = 1'b0;
        if (bus.rx_start) begin
            acc_d   = 1'b0;
            cnt_d   = '0;
            len_d   = eff_len;
            ptype_d = par_type_e'(bus.par_type);
            pen_d   = bus.par_en;
        end else if (state_q == RX_ACCUM && bus.rx_bit_valid) begin
            acc_d = acc_q ^ bus.rx_bit;
            cnt_d = cnt_q + 1'b1;
        end else if (state_q == RX_WAIT_PAR && bus.rx_par_valid) begin
            err_d = (bus.rx_par_bit != rx_exp);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_q <= '0;
        end else if (bus.err_cnt_clr) begin
            err_cnt_q <= '0;
        end else if (par_err_q && err_cnt_q != '1) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign bus.par_err = par_err_q;
    assign bus.rx_busy = (state_q != RX_IDLE);
    assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_uart_parity_engine.sv
// Bench for uart_parity_engine: TX vector table, directed RX frames,
// randomized traffic against a popcount-based reference model.
module tb_uart_parity_engine;
    import uart_pkg::*;

    localparam int DW = 8;
    localparam int CW = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    uart_parity_engine_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    uart_parity_engine #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    int exp_cnt = 0;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int eff(input int len);
        if (len < 5 || len > DW) return DW;
        return len;
    endfunction

    // Parity from counting ones in the active bits.
    function automatic bit ref_par(input bit [7:0] w, input int len,
                                   input bit [1:0] pt);
        int ones = 0;
        for (int i = 0; i < eff(len); i++) ones += int'(w[i]);
        case (pt)
            2'd0: return (ones % 2) == 1;
            2'd1: return (ones % 2) == 0;
            2'd2: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic rx_frame(input bit [3:0] cfg_len, input bit [1:0] pt,
                            input bit pen, input bit [7:0] bits,
                            input bit pbit, input bit noise,
                            input bit clr_on_err);
        int  n = eff(int'(cfg_len));
        bit  exp_err = pen && (pbit != ref_par(bits, int'(cfg_len), pt));
        bus.data_len = cfg_len;
        bus.par_type = pt;
        bus.par_en = pen;
        bus.rx_start = 1'b1;
        tick();
        bus.rx_start = 1'b0;
        if (noise) begin
            bus.data_len = 4'($urandom);
            bus.par_type = 2'($urandom);
            bus.par_en = 1'($urandom);
        end
        for (int i = 0; i < n; i++) begin
            bus.rx_bit_valid = 1'b1;
            bus.rx_bit = bits[i];
            bus.rx_par_valid = noise ? 1'($urandom) : 1'b0;
            bus.rx_par_bit = 1'($urandom);
            tick();
        end
        bus.rx_bit_valid = 1'b0;
        bus.rx_par_valid = 1'b0;
        if (pen) begin
            check("rx_busy_waitpar", bus.rx_busy, 1);
            bus.rx_par_valid = 1'b1;
            bus.rx_par_bit = pbit;
            tick();
            bus.rx_par_valid = 1'b0;
        end else begin
            check("rx_busy_nopar", bus.rx_busy, 0);
        end
        check("par_err_pulse", bus.par_err, exp_err);
        bus.err_cnt_clr = clr_on_err;
        if (clr_on_err) exp_cnt = 0;
        else if (exp_err && exp_cnt < CMAX) exp_cnt++;
        tick();
        bus.err_cnt_clr = 1'b0;
        check("par_err_end", bus.par_err, 0);
        check("err_cnt", bus.err_cnt, exp_cnt);
        check("rx_busy_idle", bus.rx_busy, 0);
    endtask

    typedef struct {
        bit [1:0] pt;
        bit [3:0] len;
        bit [7:0] data;
        bit       exp;
    } tx_vec_t;

    tx_vec_t tv[8];
    bit      exp_par;

    initial begin
        tv[0] = '{2'd0, 4'd8,  8'hA5, 1'b0};
        tv[1] = '{2'd1, 4'd8,  8'hA5, 1'b1};
        tv[2] = '{2'd0, 4'd5,  8'hE1, 1'b1};
        tv[3] = '{2'd0, 4'd3,  8'hE1, 1'b0};
        tv[4] = '{2'd2, 4'd6,  8'h00, 1'b1};
        tv[5] = '{2'd3, 4'd7,  8'hFF, 1'b0};
        tv[6] = '{2'd1, 4'd15, 8'h01, 1'b0};
        tv[7] = '{2'd0, 4'd6,  8'hC1, 1'b1};

        bus.par_en = 1'b0;
        bus.par_type = 2'd0;
        bus.data_len = 4'd8;
        bus.data_valid = 1'b0;
        bus.parallel_data = '0;
        bus.rx_start = 1'b0;
        bus.rx_bit_valid = 1'b0;
        bus.rx_bit = 1'b0;
        bus.rx_par_valid = 1'b0;
        bus.rx_par_bit = 1'b0;
        bus.err_cnt_clr = 1'b0;

        tick();
        tick();
        check("rst_par_bit", bus.par_bit, 0);
        check("rst_par_err", bus.par_err, 0);
        check("rst_rx_busy", bus.rx_busy, 0);
        check("rst_err_cnt", bus.err_cnt, 0);
        #2 reset_n = 1'b1;
        tick();

        foreach (tv[i]) begin
            bus.par_en = 1'b1;
            bus.par_type = tv[i].pt;
            bus.data_len = tv[i].len;
            bus.parallel_data = tv[i].data;
            bus.data_valid = 1'b1;
            tick();
            bus.data_valid = 1'b0;
            check("tx_table", bus.par_bit, tv[i].exp);
        end

        exp_par = tv[7].exp;
        bus.parallel_data = 8'h01;
        tick();
        check("tx_hold_novalid", bus.par_bit, exp_par);
        bus.par_en = 1'b0;
        bus.data_valid = 1'b1;
        tick();
        check("tx_hold_noen", bus.par_bit, exp_par);

        for (int k = 0; k < 200; k++) begin
            bit [1:0] pt = 2'($urandom);
            bit [3:0] ln = 4'($urandom);
            bit [7:0] dt = 8'($urandom);
            bit pe = 1'($urandom);
            bit dv = 1'($urandom);
            bus.par_en = pe;
            bus.par_type = pt;
            bus.data_len = ln;
            bus.parallel_data = dt;
            bus.data_valid = dv;
            if (pe && dv) exp_par = ref_par(dt, int'(ln), pt);
            tick();
            check("tx_rand", bus.par_bit, exp_par);
        end
        bus.data_valid = 1'b0;

        // Odd, 7 bits with three ones: expected parity bit is 0.
        rx_frame(4'd7, 2'd1, 1'b1, 8'b0001101, 1'b0, 1'b0, 1'b0);
        rx_frame(4'd7, 2'd1, 1'b1, 8'b0001101, 1'b1, 1'b0, 1'b0);
        rx_frame(4'd8, 2'd2, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        rx_frame(4'd8, 2'd3, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        rx_frame(4'd6, 2'd0, 1'b0, 8'h15, 1'b1, 1'b0, 1'b0);

        bus.par_en = 1'b1;
        bus.par_type = 2'd0;
        bus.data_len = 4'd8;
        bus.rx_start = 1'b1;
        tick();
        bus.rx_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.rx_bit_valid = 1'b1;
            bus.rx_bit = 1'b1;
            tick();
        end
        bus.rx_bit_valid = 1'b0;
        rx_frame(4'd8, 2'd0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);

        bus.data_len = 4'd5;
        bus.par_type = 2'd2;
        bus.rx_start = 1'b1;
        tick();
        bus.rx_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.rx_bit_valid = 1'b1;
            bus.rx_bit = 1'b0;
            tick();
        end
        bus.rx_bit_valid = 1'b0;
        bus.rx_start = 1'b1;
        bus.rx_par_valid = 1'b1;
        bus.rx_par_bit = 1'b0;
        tick();
        bus.rx_start = 1'b0;
        bus.rx_par_valid = 1'b0;
        tick();
        check("restart_wait_no_err", bus.par_err, 0);
        check("restart_wait_busy", bus.rx_busy, 1);
        rx_frame(4'd5, 2'd0, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0);

        for (int k = 0; k < 150; k++) begin
            rx_frame(4'($urandom), 2'($urandom), 1'($urandom),
                     8'($urandom), 1'($urandom), 1'b1, 1'b0);
        end

        for (int k = 0; k < CMAX + 4; k++) begin
            rx_frame(4'd5, 2'd2, 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        end
        check("err_cnt_sat", bus.err_cnt, CMAX);
        rx_frame(4'd5, 2'd2, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        rx_frame(4'd5, 2'd2, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);

        bus.data_len = 4'd8;
        bus.par_en = 1'b1;
        bus.par_type = 2'd0;
        bus.parallel_data = 8'h01;
        bus.data_valid = 1'b1;
        bus.rx_start = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        bus.rx_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.rx_bit_valid = 1'b1;
            bus.rx_bit = 1'b1;
            tick();
        end
        bus.rx_bit_valid = 1'b0;
        check("pre_rst_busy", bus.rx_busy, 1);
        reset_n = 1'b0;
        #1;
        exp_cnt = 0;
        check("async_rst_busy", bus.rx_busy, 0);
        check("async_rst_err_cnt", bus.err_cnt, 0);
        check("async_rst_par_bit", bus.par_bit, 0);
        #4 reset_n = 1'b1;
        tick();
        rx_frame(4'd8, 2'd2, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
